// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding request/response slave with a
// byte-addressable word store, RV32I load/store sizing, error detection and
// a programmable fixed response latency.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | req_ready high, waiting for a request
//  WAIT  | request captured, counting down the extra wait cycles
//  RESP  | first cycle: commit store / sample load; then hold response
//        | until resp_ready
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,  // power of two, 4 .. 2**29
  parameter int WAIT_CYCLES = 1     // 0 .. 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        rd_q, wr_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic          is_load, is_store;
  logic          range_err, size_err, align_err, err_c;
  logic [31:0]   ldata, rdata_c;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic          wen;

  // Decode the captured request: errors, load extension and store lanes.
  always_comb begin
    idx       = addr_q[AW+1:2];
    word      = mem[idx];
    is_load   = rd_q & ~wr_q;
    is_store  = wr_q & ~rd_q;
    range_err = |addr_q[31:AW+2];
    size_err  = 1'b0;
    align_err = 1'b0;
    ldata     = 32'd0;
    be        = 4'b0000;
    wlane     = wdata_q;

    if (is_load)
      size_err = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);
    else if (is_store)
      size_err = (f3_q != 3'b000) && (f3_q != 3'b001) && (f3_q != 3'b010);

    // Halfword sizes are x01, word is 010; other encodings already errored.
    if (f3_q[1:0] == 2'b01)
      align_err = addr_q[0];
    else if (f3_q[1:0] == 2'b10)
      align_err = (addr_q[1:0] != 2'b00);

    err_c = (rd_q & wr_q) | ((is_load | is_store) & (range_err | size_err | align_err));

    case (f3_q[1:0])
      2'b00: begin
        logic [7:0] b;
        b     = word[8*addr_q[1:0] +: 8];
        ldata = f3_q[2] ? {24'd0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        logic [15:0] h;
        h     = addr_q[1] ? word[31:16] : word[15:0];
        ldata = f3_q[2] ? {16'd0, h} : {{16{h[15]}}, h};
      end
      default: ldata = word;
    endcase

    rdata_c = (is_load && !err_c) ? ldata : 32'd0;

    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: be = 4'b1111;
    endcase

    // Commit in the same cycle the response is registered.
    wen = (state == RESP) && !resp_valid && is_store && !err_c;
  end

  // Request/response sequencing with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      rdata      <= 32'd0;
      err        <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            rd_q      <= memread;
            wr_q      <= memwrite;
            f3_q      <= funct3;
            addr_q    <= addr;
            wdata_q   <= wdata;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            rdata      <= rdata_c;
            err        <= err_c;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            rdata      <= 32'd0;
            err        <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-lane store into the word array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wen) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with WAIT_CYCLES=1 and
// one with WAIT_CYCLES=0 sharing stimulus, selected by sel0.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, memread, memwrite, resp_ready;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        sel0;

  logic        req_ready1, resp_valid1, err1;
  logic [31:0] rdata1;
  logic        req_ready0, resp_valid0, err0;
  logic [31:0] rdata0;

  logic        rq_rdy, rv, er;
  logic [31:0] rd;

  int n_chk  = 0;
  int n_pass = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel0), .req_ready(req_ready1),
    .memread(memread), .memwrite(memwrite), .funct3(funct3), .addr(addr),
    .wdata(wdata), .resp_valid(resp_valid1), .resp_ready(resp_ready),
    .rdata(rdata1), .err(err1));

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel0), .req_ready(req_ready0),
    .memread(memread), .memwrite(memwrite), .funct3(funct3), .addr(addr),
    .wdata(wdata), .resp_valid(resp_valid0), .resp_ready(resp_ready),
    .rdata(rdata0), .err(err0));

  assign rq_rdy = sel0 ? req_ready0  : req_ready1;
  assign rv     = sel0 ? resp_valid0 : resp_valid1;
  assign rd     = sel0 ? rdata0      : rdata1;
  assign er     = sel0 ? err0        : err1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!rq_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rq_rdy) check({tag, "_ready_timeout"}, 32'(n), 32'd0);
  endtask

  // One request: scoreboard push on drive, pop/compare when the response shows.
  task automatic xact(input string tag, input logic r, input logic w,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_er,
                      input int lat, input int hold);
    int n;
    logic [32:0] e, snap;
    exp_q.push_back({exp_er, exp_rd});
    wait_ready(tag);
    memread = r; memwrite = w; funct3 = f3; addr = a; wdata = d;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    memread = 1'($urandom); memwrite = 1'($urandom);
    funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    n = 0;
    while (!rv && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    snap = {er, rd};
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, "_stall"}, {28'd0, rv, rq_rdy, (({er, rd} == snap) ? 1'b1 : 1'b0), 1'b0},
            {28'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    req_valid = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_rdata"}, rd, e[31:0]);
    check({tag, "_err"}, {31'd0, er}, {31'd0, e[32]});
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, "_idle"}, {30'd0, rv, rq_rdy}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    logic no_resp;
    rst = 1'b1; sel0 = 1'b0;
    req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0; resp_ready = 1'b0;
    funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {rd[30:0], er}, 32'd0);
    check("reset_hs", {30'd0, rv, rq_rdy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("reset_release_ready", {31'd0, rq_rdy}, 32'd1);

    xact("sw_10",   0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 0);
    xact("lw_10",   1, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 0);
    xact("sb_13",   0, 1, 3'b000, 32'h13, 32'h00000080, 32'h0,        0, 2, 0);
    xact("lb_13",   1, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 0, 2, 0);
    xact("lbu_13",  1, 0, 3'b100, 32'h13, 32'h0,        32'h00000080, 0, 2, 0);
    xact("lw_10b",  1, 0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 0, 2, 0);
    xact("lh_11",   1, 0, 3'b001, 32'h11, 32'h0,        32'h0,        1, 2, 0);
    xact("sw_12",   0, 1, 3'b010, 32'h12, 32'h12345678, 32'h0,        1, 2, 0);
    xact("ld_f011", 1, 0, 3'b011, 32'h10, 32'h0,        32'h0,        1, 2, 0);
    xact("lw_oor",  1, 0, 3'b010, 32'h400, 32'h0,       32'h0,        1, 2, 0);
    xact("sw_oor",  0, 1, 3'b010, 32'h410, 32'h0,       32'h0,        1, 2, 0);
    xact("sw_f011", 0, 1, 3'b011, 32'h10, 32'h0,        32'h0,        1, 2, 0);
    xact("lw_10c",  1, 0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 0, 2, 0);
    xact("lh_12",   1, 0, 3'b001, 32'h12, 32'h0,        32'hFFFF80AD, 0, 2, 0);
    xact("lhu_10",  1, 0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 0, 2, 0);
    xact("sh_12",   0, 1, 3'b001, 32'h12, 32'hAAAA7FFF, 32'h0,        0, 2, 0);
    xact("lw_stall",1, 0, 3'b010, 32'h10, 32'h0,        32'h7FFFBEEF, 0, 2, 5);

    // Store in flight when reset hits must be dropped.
    xact("sw_20",   0, 1, 3'b010, 32'h20, 32'h11111111, 32'h0,        0, 2, 0);
    wait_ready("abort");
    memread = 1'b0; memwrite = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_outs", {rd[30:0], er}, 32'd0);
    check("abort_hs", {30'd0, rv, rq_rdy}, 32'd0);
    no_resp = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (rv) no_resp = 1'b0;
    end
    @(negedge clk); rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rv) no_resp = 1'b0;
    end
    check("abort_no_resp", {31'd0, no_resp}, 32'd1);
    xact("lw_20",   1, 0, 3'b010, 32'h20, 32'h0,        32'h11111111, 0, 2, 0);

    xact("rdwr",    1, 1, 3'b010, 32'h20, 32'hAAAAAAAA, 32'h0,        1, 2, 0);
    xact("lw_20b",  1, 0, 3'b010, 32'h20, 32'h0,        32'h11111111, 0, 2, 0);
    xact("noop",    0, 0, 3'b111, 32'h401, 32'h0,       32'h0,        0, 2, 0);

    @(negedge clk); sel0 = 1'b1;
    xact("w0_sw",   0, 1, 3'b010, 32'h4, 32'hCAFEF00D,  32'h0,        0, 1, 0);
    xact("w0_lw",   1, 0, 3'b010, 32'h4, 32'h0,         32'hCAFEF00D, 0, 1, 2);
    xact("w0_lb",   1, 0, 3'b000, 32'h6, 32'h0,         32'hFFFFFFFE, 0, 1, 0);
    xact("w0_noop", 0, 0, 3'b010, 32'h4, 32'h0,         32'h0,        0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, 256, number of 32-bit storage words; power of two, at least 4.
REQ-002 Parameter: WAIT_CYCLES, 1, extra wait cycles between request accept and response; range 0..15.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  core presents a data-memory request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 memread  input  1  request is a load.
REQ-009 memwrite  input  1  request is a store.
REQ-010 funct3  input  3  access size and sign (RV32I load/store funct3).
REQ-011 addr  input  32  byte address.
REQ-012 wdata  input  32  store data, right-aligned.
REQ-013 resp_valid  output  1  response available.
REQ-014 resp_ready  input  1  core accepts the response.
REQ-015 rdata  output  32  extended load data; 0 for stores, errors and no-op requests.
REQ-016 err  output  1  response carries an error; valid only with resp_valid.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, RESP; req_ready = 1 only in IDLE with rst low.
REQ-018 Accept = req_valid & req_ready at a rising edge; addr, funct3, wdata, memread, memwrite captured on accept; later input changes are ignored until the next accept.
REQ-019 On accept: WAIT_CYCLES = 0 -> RESP; otherwise -> WAIT with a counter loaded to WAIT_CYCLES-1.
REQ-020 WAIT: counter decrements each cycle; at 0 -> RESP.
REQ-021 resp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accept edge and stay high until resp_valid & resp_ready.
REQ-022 RESP: on handshake -> IDLE; a new request can be accepted no earlier than the cycle after the handshake (no overlap, one outstanding request).
REQ-023 rdata and err SHALL be registered and stable for as long as resp_valid is high.
REQ-024 Word index = addr[log2(DEPTH_WORDS)+1:2]; addr[31:2] >= DEPTH_WORDS -> err=1.
REQ-025 Loads: 000 LB sign-extend byte addr[1:0]; 001 LH sign-extend half addr[1]; 010 LW; 100 LBU, 101 LHU zero-extend; 011, 110, 111 -> err=1.
REQ-026 Stores: 000 SB writes byte lane addr[1:0]; 001 SH writes lanes {2*addr[1]+1, 2*addr[1]}; 010 SW writes all lanes; other funct3 -> err=1; unselected lanes are unchanged.
REQ-027 Misalignment: a halfword with addr[0]=1, or a word with addr[1:0]!=0 -> err=1.
REQ-028 memread and memwrite both high -> err=1, no write, rdata=0.
REQ-029 Both low -> no-op; response still issued with err=0 and rdata=0.
REQ-030 Store commit SHALL occur at the same edge resp_valid rises, and only if err=0; an errored store modifies nothing.
REQ-031 Load data SHALL be sampled at the edge resp_valid rises, so a load sees all previously committed stores.

Reset
REQ-032 While rst is high: state=IDLE, req_ready=0, resp_valid=0, rdata=0, err=0, counter=0.
REQ-033 Reset asserted in WAIT or RESP SHALL abort the request; a store not yet committed is dropped and no response is issued.
REQ-034 Storage contents are not reset and are undefined until written.
REQ-035 After reset deasserts, req_ready=1 on the first clock edge with the FSM in IDLE.

Verification
REQ-036 SW 0xDEADBEEF to 0x10, then LW 0x10 with WAIT_CYCLES=1 -> resp_valid 2 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-037 SB 0x80 to 0x13, then LB 0x13 -> rdata=0xFFFFFF80; LBU 0x13 -> rdata=0x00000080; LW 0x10 -> rdata=0x80ADBEEF.
REQ-038 LH 0x11, SW 0x12, funct3=011 load, and addr=4*DEPTH_WORDS -> each response err=1, rdata=0, memory unchanged (LW 0x10 still returns its prior value).
REQ-039 Hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err stable, req_ready=0, and a new req_valid is not accepted; handshake -> IDLE next cycle.
REQ-040 Assert rst during WAIT of SW 0x55 to 0x20 -> no response, all outputs 0; a later LW 0x20 returns the pre-reset contents.
REQ-041 Set memread=memwrite=1 -> err=1, no write; with both low -> err=0, rdata=0; with WAIT_CYCLES=0 -> resp_valid 1 cycle after accept.
